// File: rtl/flap_game_ctrl.sv
// Flap game supervisor: bird/pipe collision, scoring, phase FSM.
// Optional FLAP_HIGHSCORE_EN adds a best-score register on hiscore.
module flap_game_ctrl #(
  parameter logic [7:0] JUMP_KEY_A = 8'h1A,
  parameter logic [7:0] JUMP_KEY_B = 8'hCC,
  parameter logic [9:0] GAP_H      = 10'd120,
  parameter logic [5:0] DIE_FRAMES = 6'd30,
  parameter logic [9:0] SCORE_MAX  = 10'd999
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] key,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallW,
  input  logic [9:0] BallH,
  input  logic       gameover,
  input  logic [9:0] ObsX,
  input  logic [9:0] ObsW,
  input  logic [9:0] ObsGapY,
  output logic       rdy,
  output logic       restart,
  output logic [9:0] score,
  output logic [1:0] state,
  output logic       hit
`ifdef FLAP_HIGHSCORE_EN
  ,
  output logic [9:0] hiscore
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } st_t;

  st_t        st_q;
  logic [5:0] die_cnt;
  logic       passed;
  logic       key_prev;

  logic        jump;
  logic        press;
  logic [10:0] obs_r;
  logic [10:0] ball_r;
  logic [10:0] ball_b;
  logic [10:0] gap_b;
  logic        xov;
  logic        yout;
  logic        coll;
  logic        cleared;
  logic [9:0]  score_inc;

  assign state = st_q;

  assign jump  = (key == JUMP_KEY_A) || (key == JUMP_KEY_B);
  assign press = jump && !key_prev;

  // 11-bit sums so edge positions near 1023 cannot wrap
  assign obs_r  = {1'b0, ObsX} + {1'b0, ObsW};
  assign ball_r = {1'b0, BallX} + {1'b0, BallW};
  assign ball_b = {1'b0, BallY} + {1'b0, BallH};
  assign gap_b  = {1'b0, ObsGapY} + {1'b0, GAP_H};

  assign xov  = ({1'b0, BallX} < obs_r) && (ball_r > {1'b0, ObsX});
  assign yout = ({1'b0, BallY} < {1'b0, ObsGapY}) || (ball_b > gap_b);
  assign coll = (xov && yout) || gameover;

  assign cleared   = obs_r < {1'b0, BallX};
  assign score_inc = (score >= SCORE_MAX) ? SCORE_MAX : score + 10'd1;

  // Phase sequencing, scoring and registered outputs
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st_q     <= S_IDLE;
      rdy      <= 1'b0;
      restart  <= 1'b0;
      score    <= 10'd0;
      hit      <= 1'b0;
      die_cnt  <= 6'd0;
      passed   <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_prev <= jump;
      hit      <= coll;
      restart  <= 1'b0;
      unique case (st_q)
        S_IDLE, S_OVER: begin
          if (press) begin
            st_q    <= S_PLAY;
            rdy     <= 1'b1;
            restart <= 1'b1;
            score   <= 10'd0;
            passed  <= 1'b0;
          end
        end
        S_PLAY: begin
          if (hit) begin
            st_q    <= S_DYING;
            rdy     <= 1'b0;
            die_cnt <= 6'd0;
          end else if (cleared) begin
            if (!passed && !coll) begin
              score  <= score_inc;
              passed <= 1'b1;
            end
          end else begin
            passed <= 1'b0;
          end
        end
        S_DYING: begin
          if (die_cnt == DIE_FRAMES - 6'd1) begin
            st_q <= S_OVER;
          end else begin
            die_cnt <= die_cnt + 6'd1;
          end
        end
      endcase
    end
  end

`ifdef FLAP_HIGHSCORE_EN
  // Best score latched on the DYING -> OVER transition; survives restart
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      hiscore <= 10'd0;
    end else if (st_q == S_DYING && die_cnt == DIE_FRAMES - 6'd1) begin
      if (score > hiscore) hiscore <= score;
    end
  end
`endif

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Bench for flap_game_ctrl: vector tables plus scripted game sequences.
// Expected outputs queued on drive, compared one frame later.
module tb_flap_game_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] key;
  logic [9:0] BallX, BallY, BallW, BallH;
  logic       gameover;
  logic [9:0] ObsX, ObsW, ObsGapY;
  logic       rdy, restart, hit;
  logic [9:0] score;
  logic [1:0] state;
`ifdef FLAP_HIGHSCORE_EN
  logic [9:0] hiscore;
`endif

  flap_game_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallW     (BallW),
    .BallH     (BallH),
    .gameover  (gameover),
    .ObsX      (ObsX),
    .ObsW      (ObsW),
    .ObsGapY   (ObsGapY),
    .rdy       (rdy),
    .restart   (restart),
    .score     (score),
    .state     (state),
    .hit       (hit)
`ifdef FLAP_HIGHSCORE_EN
    ,
    .hiscore   (hiscore)
`endif
  );

  typedef struct {
    logic       rst;
    logic [7:0] key;
    logic       go;
    logic [9:0] ox;
    logic [9:0] gy;
    logic [1:0] st;
    logic       rdy;
    logic       rs;
    logic [9:0] sc;
    logic       hit;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mk(int r, int k, int g, int ox, int gy,
                              int s, int rd, int rs, int sc, int h);
    vec_t v;
    v.rst = 1'(r);
    v.key = 8'(k);
    v.go  = 1'(g);
    v.ox  = 10'(ox);
    v.gy  = 10'(gy);
    v.st  = 2'(s);
    v.rdy = 1'(rd);
    v.rs  = 1'(rs);
    v.sc  = 10'(sc);
    v.hit = 1'(h);
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    @(negedge frame_clk);
    Reset    = v.rst;
    key      = v.key;
    gameover = v.go;
    ObsX     = v.ox;
    ObsGapY  = v.gy;
    exp_q.push_back(v);
    @(posedge frame_clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (state !== e.st || rdy !== e.rdy || restart !== e.rs ||
        score !== e.sc || hit !== e.hit) begin
      n_bad++;
      $display("FAIL %s: got st=%0d rdy=%0b rs=%0b sc=%0d hit=%0b want st=%0d rdy=%0b rs=%0b sc=%0d hit=%0b",
               nm, state, rdy, restart, score, hit,
               e.st, e.rdy, e.rs, e.sc, e.hit);
    end
  endtask

`ifdef FLAP_HIGHSCORE_EN
  task automatic game(input int n, input int hi);
    apply(mk(0, 8'h1A, 0, 400, 200, 1, 1, 1, 0, 0), "hs_start");
    apply(mk(0, 0, 0, 400, 200, 1, 1, 0, 0, 0), "hs_play");
    for (int k = 0; k < n; k++) begin
      apply(mk(0, 0, 0, 0, 200, 1, 1, 0, k + 1, 0), "hs_pass");
      apply(mk(0, 0, 0, 400, 200, 1, 1, 0, k + 1, 0), "hs_rearm");
    end
    apply(mk(0, 0, 0, 150, 300, 1, 1, 0, n, 1), "hs_hit");
    for (int k = 0; k < 30; k++)
      apply(mk(0, 0, 0, 150, 300, 2, 0, 0, n, 1), "hs_dying");
    apply(mk(0, 0, 0, 150, 300, 3, 0, 0, n, 1), "hs_over");
    n_vec++;
    if (hiscore !== 10'(hi)) begin
      n_bad++;
      $display("FAIL hiscore: got %0d want %0d", hiscore, hi);
    end
    apply(mk(0, 0, 0, 400, 200, 3, 0, 0, n, 0), "hs_idle_over");
  endtask
`endif

  vec_t start_v[9];
  vec_t crash_v[2];

  initial begin
    Reset    = 1'b1;
    key      = 8'h00;
    gameover = 1'b0;
    BallX    = 10'd100;
    BallW    = 10'd86;
    BallY    = 10'd240;
    BallH    = 10'd26;
    ObsX     = 10'd400;
    ObsW     = 10'd40;
    ObsGapY  = 10'd200;

    start_v[0] = mk(1, 8'h00, 0, 400, 200, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      start_v[i] = mk(0, 8'h00, 0, 400, 200, 0, 0, 0, 0, 0);
    start_v[6] = mk(0, 8'h1A, 0, 400, 200, 1, 1, 1, 0, 0);
    start_v[7] = mk(0, 8'h1A, 0, 400, 200, 1, 1, 0, 0, 0);
    start_v[8] = mk(0, 8'h00, 0, 400, 200, 1, 1, 0, 0, 0);

    crash_v[0] = mk(0, 8'h00, 0, 150, 300, 1, 1, 0, 2, 1);
    crash_v[1] = mk(0, 8'h00, 0, 150, 300, 2, 0, 0, 2, 1);

    for (int i = 0; i < 9; i++) apply(start_v[i], "start");

    for (int s = 0; s < 2; s++)
      for (int x = 400; x >= 0; x -= 4)
        apply(mk(0, 0, 0, x, 200, 1, 1, 0,
                 s + ((x + 40 < 100) ? 1 : 0), 0), "sweep");

    for (int i = 0; i < 2; i++) apply(crash_v[i], "crash");
    for (int i = 1; i < 30; i++)
      apply(mk(0, 8'hCC, 0, 400, 200, 2, 0, 0, 2, 0), "dying");
    apply(mk(0, 8'hCC, 0, 400, 200, 3, 0, 0, 2, 0), "to_over");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 8'hCC, 0, 400, 200, 3, 0, 0, 2, 0), "over_held");
    apply(mk(0, 8'h00, 0, 400, 200, 3, 0, 0, 2, 0), "over_rel");
    apply(mk(0, 8'hCC, 0, 400, 200, 1, 1, 1, 0, 0), "replay");
    apply(mk(0, 8'hCC, 0, 400, 200, 1, 1, 0, 0, 0), "replay2");

    apply(mk(0, 8'hCC, 1, 400, 200, 1, 1, 0, 0, 1), "go_hit");
    apply(mk(0, 8'hCC, 1, 400, 200, 2, 0, 0, 0, 1), "go_dying");
    for (int i = 1; i < 30; i++)
      apply(mk(0, 8'hCC, 1, 400, 200, 2, 0, 0, 0, 1), "go_dying");
    apply(mk(0, 8'hCC, 1, 400, 200, 3, 0, 0, 0, 1), "go_over");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 8'hCC, 1, 400, 200, 3, 0, 0, 0, 1), "go_over_held");
    apply(mk(0, 8'h00, 0, 400, 200, 3, 0, 0, 0, 0), "go_rel");
    apply(mk(0, 8'hCC, 0, 400, 200, 1, 1, 1, 0, 0), "go_replay");
    apply(mk(0, 8'h00, 0, 400, 200, 1, 1, 0, 0, 0), "go_play");

    for (int i = 0; i < 1000; i++) begin
      apply(mk(0, 0, 0, 0, 200, 1, 1, 0,
               (i + 1 > 999) ? 999 : i + 1, 0), "sat_pass");
      apply(mk(0, 0, 0, 400, 200, 1, 1, 0,
               (i + 1 > 999) ? 999 : i + 1, 0), "sat_rearm");
    end
    apply(mk(0, 0, 0, 0, 200, 1, 1, 0, 999, 0), "sat_hold");

    apply(mk(0, 8'h00, 0, 150, 300, 1, 1, 0, 999, 1), "ph_hit");
    apply(mk(0, 8'h1A, 0, 150, 300, 2, 0, 0, 999, 1), "ph_dying");
    apply(mk(0, 8'h1A, 0, 150, 300, 2, 0, 0, 999, 1), "ph_dying2");

    apply(mk(1, 8'h1A, 0, 150, 300, 0, 0, 0, 0, 0), "mid_reset");
    apply(mk(0, 8'h00, 0, 400, 200, 0, 0, 0, 0, 0), "post_reset");

`ifdef FLAP_HIGHSCORE_EN
    game(5, 5);
    game(3, 5);
    apply(mk(1, 0, 0, 400, 200, 0, 0, 0, 0, 0), "hs_reset");
    n_vec++;
    if (hiscore !== 10'd0) begin
      n_bad++;
      $display("FAIL hiscore_reset: got %0d want 0", hiscore);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
